// File: rtl/multiply_accumulate_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : multiply_accumulate_unit_if
// Purpose  : request/response bundle between control unit and multiply engine
// Revision : 1.0
// ============================================================================
interface multiply_accumulate_unit_if #(
  parameter int WIDTH = 32
);
  logic                 in_valid;
  logic                 in_ready;
  logic [3:0]           opcode;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic [WIDTH-1:0]     c;
  logic [WIDTH-1:0]     d;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   result;
  logic [1:0]           flags;
  logic                 illegal;

  modport slave (
    input  in_valid, opcode, a, b, c, d, out_ready,
    output in_ready, out_valid, result, flags, illegal
  );

  modport master (
    output in_valid, opcode, a, b, c, d, out_ready,
    input  in_ready, out_valid, result, flags, illegal
  );
endinterface
`default_nettype wire

// File: rtl/multiply_accumulate_unit.sv
`default_nettype none
// ============================================================================
// Module   : multiply_accumulate_unit
// Purpose  : iterative shift-add mul/mla/umull/umlal/smull/smlal engine;
//            MULTIPLY_ACCUMULATE_UNIT_EARLY_TERMINATE_EN enables early exit
// Revision : 1.0
// ============================================================================
module multiply_accumulate_unit #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  multiply_accumulate_unit_if.slave   bus
);

  localparam int W2    = 2 * WIDTH;
  localparam int STEPS = WIDTH / BITS_PER_CYCLE;
  localparam int CW    = $clog2(STEPS + 1);

  localparam logic [3:0] OP_MUL   = 4'b0000;
  localparam logic [3:0] OP_MLA   = 4'b0001;
  localparam logic [3:0] OP_UMULL = 4'b0100;
  localparam logic [3:0] OP_UMLAL = 4'b0101;
  localparam logic [3:0] OP_SMULL = 4'b0110;
  localparam logic [3:0] OP_SMLAL = 4'b0111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic             bad_op_q, bad_op_d;
  logic             sign_q, sign_d;
  logic [W2-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] c_q, c_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [CW-1:0]    count_q, count_d;
  logic [W2-1:0]    sum_q, sum_d;
  logic [W2-1:0]    result_q, result_d;
  logic [1:0]       flags_q, flags_d;
  logic             illegal_q, illegal_d;

  logic             in_legal;
  logic             in_signed;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [W2-1:0]    addend;
  logic [WIDTH-1:0] mplier_shift;
  logic             early_exit;
  logic [W2-1:0]    fixed_sum;
  logic [W2-1:0]    final_res;
  logic [1:0]       final_flags;

  assign in_legal  = (bus.opcode == OP_MUL)   || (bus.opcode == OP_MLA)   ||
                     (bus.opcode == OP_UMULL) || (bus.opcode == OP_UMLAL) ||
                     (bus.opcode == OP_SMULL) || (bus.opcode == OP_SMLAL);
  assign in_signed = (bus.opcode == OP_SMULL) || (bus.opcode == OP_SMLAL);

  // Two's-complement negate of the most negative value yields its unsigned magnitude.
  assign a_mag = (in_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign b_mag = (in_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;

  always_comb begin
    addend = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (mplier_q[i]) begin
        addend = addend + (mcand_q << i);
      end
    end
  end

  assign mplier_shift = mplier_q >> BITS_PER_CYCLE;

`ifdef MULTIPLY_ACCUMULATE_UNIT_EARLY_TERMINATE_EN
  assign early_exit = (mplier_shift == '0);
`else
  assign early_exit = 1'b0;
`endif

  assign fixed_sum = sign_q ? -sum_q : sum_q;

  always_comb begin
    final_res = fixed_sum;
    case (op_q)
      OP_MUL:             final_res = {{WIDTH{1'b0}}, fixed_sum[WIDTH-1:0]};
      OP_MLA:             final_res = {{WIDTH{1'b0}}, fixed_sum[WIDTH-1:0] + c_q};
      OP_UMLAL, OP_SMLAL: final_res = fixed_sum + {c_q, d_q};
      default:            final_res = fixed_sum;
    endcase
    // Long forms have op bit 2 set; short forms judge flags on the low word only.
    if (op_q[2]) begin
      final_flags = {final_res[W2-1], final_res == '0};
    end else begin
      final_flags = {final_res[WIDTH-1], final_res[WIDTH-1:0] == '0};
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    bad_op_d  = bad_op_q;
    sign_d    = sign_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    c_d       = c_q;
    d_d       = d_q;
    count_d   = count_q;
    sum_d     = sum_q;
    result_d  = result_q;
    flags_d   = flags_q;
    illegal_d = illegal_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          op_d     = bus.opcode;
          c_d      = bus.c;
          d_d      = bus.d;
          bad_op_d = !in_legal;
          sign_d   = in_signed && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          mcand_d  = {{WIDTH{1'b0}}, a_mag};
          mplier_d = b_mag;
          count_d  = CW'(STEPS);
          sum_d    = '0;
          // Illegal requests bypass the datapath but still take one cycle.
          state_d  = in_legal ? S_RUN : S_FIX;
        end
      end
      S_RUN: begin
        sum_d    = sum_q + addend;
        mcand_d  = mcand_q << BITS_PER_CYCLE;
        mplier_d = mplier_shift;
        count_d  = count_q - CW'(1);
        if ((count_q == CW'(1)) || early_exit) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        if (bad_op_q) begin
          result_d  = '0;
          flags_d   = 2'b01;
          illegal_d = 1'b1;
        end else begin
          result_d  = final_res;
          flags_d   = final_flags;
          illegal_d = 1'b0;
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      bad_op_q  <= 1'b0;
      sign_q    <= 1'b0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      c_q       <= '0;
      d_q       <= '0;
      count_q   <= '0;
      sum_q     <= '0;
      result_q  <= '0;
      flags_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      bad_op_q  <= bad_op_d;
      sign_q    <= sign_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      c_q       <= c_d;
      d_q       <= d_d;
      count_q   <= count_d;
      sum_q     <= sum_d;
      result_q  <= result_d;
      flags_q   <= flags_d;
      illegal_q <= illegal_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.result    = result_q;
  assign bus.flags     = flags_q;
  assign bus.illegal   = illegal_q;

endmodule
`default_nettype wire
